fsk_frame_tx: RTL and testbench
===============================

FSK_FRAME_TX -- requirements
Module: fsk_frame_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16: clk cycles per transmitted symbol, legal range 2..65535.
REQ-002 SHALL provide parameter HALF_MARK, default 2: clk cycles per half-period of the mark (bit 1) tone, legal range 1..255.
REQ-003 SHALL provide parameter HALF_SPACE, default 4: clk cycles per half-period of the space (bit 0) tone, legal range 1..255, not equal to HALF_MARK.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic samples on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port data, input, 8 bits: byte to transmit, sampled on handshake.
REQ-007 SHALL have port valid, input, 1 bit: data holds a byte to send.
REQ-008 SHALL have port ready, output, 1 bit: block can accept a byte.
REQ-009 SHALL have port q, output, 1 bit: FSK tone output.
REQ-010 SHALL have port line_bit, output, 1 bit: logical symbol currently being keyed (1 = mark).
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 Handshake SHALL occur on a rising edge with valid=1 and ready=1; data is captured into a shift register on that edge.
REQ-014 ready SHALL be 1 only in IDLE; it SHALL drop on the edge following the handshake.
REQ-015 IDLE -> START on handshake; line_bit=0 and busy=1 from the next cycle.
REQ-016 START SHALL last CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit index counts 0..7; after bit 7, go to STOP.
REQ-018 STOP SHALL key line_bit=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-019 A frame SHALL be exactly 10*CLKS_PER_BIT cycles from the first START cycle to the first IDLE cycle.
REQ-020 There SHALL be at least one IDLE cycle, with ready=1, between frames.
REQ-021 In IDLE, line_bit SHALL be 1, so a mark tone runs continuously.
REQ-022 valid while ready=0 SHALL be ignored; data and valid changes mid-frame SHALL NOT affect the frame in flight.
REQ-023 Bit timing SHALL use a counter of ceil(log2(CLKS_PER_BIT)) bits that runs 0..CLKS_PER_BIT-1 and wraps to 0 at each symbol boundary.
REQ-024 Tone generator SHALL use an 8-bit counter tone_cnt and half = (line_bit ? HALF_MARK : HALF_SPACE).
  - Each cycle, if tone_cnt >= half-1: toggle q and clear tone_cnt.
  - Otherwise: increment tone_cnt.
REQ-025 Tone SHALL be phase-continuous: tone_cnt and q are never cleared at symbol boundaries.
  - When switching to a shorter half, the >= compare forces a toggle on the first cycle of the new symbol.
REQ-026 Tone SHALL run in every state, including IDLE, whenever rst_n=1.

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL set state=IDLE, ready=0, busy=0, q=0, line_bit=1, tone_cnt=0, bit counter=0, and clear the shift register.
REQ-028 ready SHALL rise on the first rising edge with rst_n=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame; the aborted byte is never resumed.
REQ-030 rst_n SHALL take no effect between clock edges.

Verification
REQ-031 Reset release, defaults, valid=0 -> ready=1 after 1 cycle, busy=0, line_bit=1; q toggles every 2 cycles (period 4).
REQ-032 Send data=0xA5 -> line_bit sequence 0,1,0,1,0,0,1,0,1,1, each symbol 16 cycles; busy=1 for 160 cycles; ready returns on cycle 161.
REQ-033 During a space symbol -> q half-period is 4 cycles; across the mark/space transition -> no q glitch shorter than 1 cycle and no q reset.
REQ-034 valid held high with data=0x00 then 0xFF -> two frames separated by exactly 1 ready=1 cycle; the second frame shows 8 mark data symbols.
REQ-035 rst_n=0 for 1 cycle at cycle 50 of a frame -> next cycle q=0, busy=0, ready=0; ready=1 one cycle after release; no residual symbols.
REQ-036 data changed and valid toggled mid-frame -> transmitted bits match the byte captured at the handshake.

Source files
------------

// File: rtl/fsk_frame_tx.sv
`default_nettype none
// ============================================================================
// fsk_frame_tx : start/8 data (LSB first)/stop framer keying a phase-continuous
//                two-tone FSK generator.                      Revision: 1.0
// ============================================================================
module fsk_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int HALF_MARK    = 2,
  parameter int HALF_SPACE   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       q,
  output logic       line_bit,
  output logic       busy
);

  localparam int              C_CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [C_CW-1:0] C_LAST       = C_CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      C_HALF_M_M1  = 8'(HALF_MARK - 1);
  localparam logic [7:0]      C_HALF_S_M1  = 8'(HALF_SPACE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [C_CW-1:0] r_bit_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_ready;
  logic [7:0]      r_tone_cnt;
  logic            r_q;
  logic [7:0]      w_half_m1;
  logic            w_hs;
  logic            w_sym_end;

  // r_ready is only ever set while the next state is IDLE
  assign w_hs      = r_ready & valid;
  assign w_sym_end = (r_bit_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs)                     w_next = S_START;
      S_START: if (w_sym_end)                w_next = S_DATA;
      S_DATA:  if (w_sym_end && r_idx == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_sym_end)                w_next = S_IDLE;
      default:                               w_next = S_IDLE;
    endcase
  end

  always_comb begin
    line_bit = 1'b1;
    busy     = 1'b0;
    case (r_state)
      S_START: begin line_bit = 1'b0;       busy = 1'b1; end
      S_DATA:  begin line_bit = r_shift[0]; busy = 1'b1; end
      S_STOP:  begin line_bit = 1'b1;       busy = 1'b1; end
      default: begin line_bit = 1'b1;       busy = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready   <= 1'b0;
      r_bit_cnt <= '0;
      r_idx     <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
        r_idx     <= 3'd0;
        if (w_hs) r_shift <= data;
      end else begin
        r_bit_cnt <= w_sym_end ? '0 : r_bit_cnt + C_CW'(1);
        if (r_state == S_DATA && w_sym_end) begin
          r_idx   <= r_idx + 3'd1;
          r_shift <= {1'b0, r_shift[7:1]};
        end
      end
    end
  end

  // Tone state is never touched at symbol boundaries, keeping the phase continuous
  assign w_half_m1 = line_bit ? C_HALF_M_M1 : C_HALF_S_M1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tone_cnt <= 8'd0;
      r_q        <= 1'b0;
    end else if (r_tone_cnt >= w_half_m1) begin
      r_tone_cnt <= 8'd0;
      r_q        <= ~r_q;
    end else begin
      r_tone_cnt <= r_tone_cnt + 8'd1;
    end
  end

  assign ready = r_ready;
  assign q     = r_q;

endmodule
`default_nettype wire

// File: tb/tb_fsk_frame_tx.sv
`default_nettype none
// ============================================================================
// tb_fsk_frame_tx : scoreboard bench for fsk_frame_tx.          Revision: 1.0
// ============================================================================
module tb_fsk_frame_tx;

  localparam int CPB = 16;
  localparam int HM  = 2;
  localparam int HS  = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       q;
  logic       line_bit;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb_q[$];
  logic       mon_en     = 1'b0;
  logic       abort_flag = 1'b0;
  logic       in_frame   = 1'b0;
  int         cyc        = 0;
  logic [9:0] exp_sym    = 10'h3FF;
  logic       m_line     = 1'b1;
  logic       mq         = 1'b0;
  int         mcnt       = 0;

  fsk_frame_tx #(
    .CLKS_PER_BIT(CPB),
    .HALF_MARK   (HM),
    .HALF_SPACE  (HS)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .q       (q),
    .line_bit(line_bit),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Byte accepted on this edge goes to the scoreboard
  always @(posedge clk) begin
    if (rst_n && valid && ready) sb_q.push_back(data);
  end

  // Reference tone driven by the expected symbol, not the DUT's line_bit
  always @(posedge clk) begin
    if (!rst_n) begin
      mq   = 1'b0;
      mcnt = 0;
    end else if (mcnt >= (m_line ? HM : HS) - 1) begin
      mq   = ~mq;
      mcnt = 0;
    end else begin
      mcnt = mcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !in_frame) begin
        in_frame = 1'b1;
        cyc      = 0;
        if (sb_q.size() == 0) begin
          check("frame_unexpected", 32'd1, 32'd0);
          exp_sym = 10'h3FF;
        end else begin
          exp_sym = {1'b1, sb_q.pop_front(), 1'b0};
        end
      end else if (!busy && in_frame) begin
        in_frame = 1'b0;
        if (!abort_flag) begin
          check("frame_len", cyc, 10 * CPB);
          check("ready_after_frame", {31'd0, ready}, 32'd1);
        end
        abort_flag = 1'b0;
      end

      if (in_frame) begin
        m_line = (cyc / CPB < 10) ? exp_sym[cyc / CPB] : 1'b1;
        check("line_bit", {31'd0, line_bit}, {31'd0, m_line});
        check("ready_in_frame", {31'd0, ready}, 32'd0);
        cyc++;
      end else begin
        m_line = 1'b1;
        check("line_bit_idle", {31'd0, line_bit}, 32'd1);
      end
      check("q_tone", {31'd0, q}, {31'd0, mq});
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit keep_valid);
    bit ok = 1'b0;
    data  = b;
    valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("handshake_timeout", {31'd0, ok}, 32'd1);
    @(negedge clk);
    if (!keep_valid) valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_q", {31'd0, q}, 32'd0);
    check("rst_line_bit", {31'd0, line_bit}, 32'd1);
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // Idle mark tone: q toggles every 2 cycles from reset release
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("ready_after_rst", {31'd0, ready}, 32'd1);
        check("busy_after_rst", {31'd0, busy}, 32'd0);
      end
      check("idle_tone", {31'd0, q}, (k / 2) % 2);
    end

    send_byte(8'hA5, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk);

    // Back-to-back frames with valid held high
    send_byte(8'h00, 1'b1);
    data = 8'hFF;
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    gap = 0;
    for (int i = 0; i < 20 && !busy; i++) begin
      if (ready) gap++;
      @(negedge clk);
    end
    valid = 1'b0;
    check("gap_ready_cycles", gap, 1);
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset at cycle 50 of a frame
    send_byte(8'h5A, 1'b0);
    repeat (49) @(negedge clk);
    abort_flag = 1'b1;
    rst_n      = 1'b0;
    @(negedge clk);
    check("abort_q", {31'd0, q}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_release", {31'd0, ready}, 32'd1);
    repeat (200) @(negedge clk);
    check("abort_no_residual", {31'd0, busy}, 32'd0);

    // Input activity mid-frame must not disturb the captured byte
    send_byte(8'h3C, 1'b0);
    data = 8'hC3;
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 0) valid = ~valid;
      @(negedge clk);
    end
    valid = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
